// File: rtl/config_pkg.sv
// Core configuration record supplying the physical memory attribute rule tables.
// Only the fields used by the PMA region walker are carried here; each class
// has a rule count plus parallel base and length tables of up to MaxRules entries.
package config_pkg;

   localparam int unsigned MaxRules = 16;
   localparam int unsigned RuleIdxW = $clog2(MaxRules);

   typedef struct packed {
      int unsigned                     NrNonIdempotentRules;
      logic [MaxRules-1:0][63:0]       NonIdempotentAddrBase;
      logic [MaxRules-1:0][63:0]       NonIdempotentLength;
      int unsigned                     NrExecuteRegionRules;
      logic [MaxRules-1:0][63:0]       ExecuteRegionAddrBase;
      logic [MaxRules-1:0][63:0]       ExecuteRegionLength;
      int unsigned                     NrCachedRegionRules;
      logic [MaxRules-1:0][63:0]       CachedRegionAddrBase;
      logic [MaxRules-1:0][63:0]       CachedRegionLength;
   } cva6_cfg_t;

endpackage

// File: rtl/pma_walker_pkg.sv
// Shared types for the PMA region walker: the lookup FSM states, the
// three-class response record and a helper that sizes the walk.
package pma_walker_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WALK,
      RESP
   } walker_state_e;

   typedef struct packed {
      logic exec;
      logic cached;
      logic nonidem;
   } pma_resp_t;

   // The walk length is set by whichever class has the most rules.
   function automatic int unsigned maxRules(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/pma_range_match.sv
// Half-open range comparator: hit when base <= addr < base + length.
// The end address is formed one bit wider than the address so that a region
// running past the top of the address space cannot wrap around and claim low
// addresses. A zero-length region is empty and never hits.
module pma_range_match #(
   parameter int unsigned AddrW = 64
) (
   input  logic [AddrW-1:0] addr_i,
   input  logic [AddrW-1:0] base_i,
   input  logic [AddrW-1:0] length_i,
   output logic             hit_o
);

   logic [AddrW:0] endAddr;

   // Widened end-address compare plus the lower-bound and empty-region checks.
   always_comb begin
      endAddr = {1'b0, base_i} + {1'b0, length_i};
      hit_o   = (length_i != '0) && (addr_i >= base_i) && ({1'b0, addr_i} < endAddr);
   end

endmodule

// File: rtl/pma_region_walker.sv
// Sequential PMA classifier. An accepted address is compared against one rule
// index per cycle for the execute, cached and non-idempotent classes in
// parallel; hits accumulate into sticky flags that are presented once the
// longest rule table has been walked. Rule tables are fixed by CVA6Cfg.
module pma_region_walker
   import pma_walker_pkg::*;
#(
   parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_t'(0),
   parameter int unsigned           AddrW   = 64
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [AddrW-1:0] req_addr_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic             resp_exec_o,
   output logic             resp_cached_o,
   output logic             resp_nonidem_o
);

   localparam int unsigned IdxW     = config_pkg::RuleIdxW;
   localparam int unsigned NrExec   = CVA6Cfg.NrExecuteRegionRules;
   localparam int unsigned NrCached = CVA6Cfg.NrCachedRegionRules;
   localparam int unsigned NrNonId  = CVA6Cfg.NrNonIdempotentRules;
   localparam int unsigned NMax     = maxRules(NrExec, NrCached, NrNonId);

   walker_state_e    stateQ, stateD;
   logic [IdxW-1:0]  idxQ, idxD;
   pma_resp_t        flagsQ, flagsD;
   logic [AddrW-1:0] addrQ, addrD;

   logic [AddrW-1:0] execBase, execLen;
   logic [AddrW-1:0] cachedBase, cachedLen;
   logic [AddrW-1:0] nonIdBase, nonIdLen;
   logic             execHit, cachedHit, nonIdHit;
   pma_resp_t        ruleEn;
   pma_resp_t        hits;
   logic             lastIdx;

   // Pick the current rule of each class; classes whose table is shorter than
   // the walk are masked off once the index runs past their last rule.
   always_comb begin
      execBase       = CVA6Cfg.ExecuteRegionAddrBase[idxQ][AddrW-1:0];
      execLen        = CVA6Cfg.ExecuteRegionLength[idxQ][AddrW-1:0];
      cachedBase     = CVA6Cfg.CachedRegionAddrBase[idxQ][AddrW-1:0];
      cachedLen      = CVA6Cfg.CachedRegionLength[idxQ][AddrW-1:0];
      nonIdBase      = CVA6Cfg.NonIdempotentAddrBase[idxQ][AddrW-1:0];
      nonIdLen       = CVA6Cfg.NonIdempotentLength[idxQ][AddrW-1:0];
      ruleEn.exec    = (32'(idxQ) < NrExec);
      ruleEn.cached  = (32'(idxQ) < NrCached);
      ruleEn.nonidem = (32'(idxQ) < NrNonId);
   end

   pma_range_match #(.AddrW(AddrW)) uExecMatch (
      .addr_i   (addrQ),
      .base_i   (execBase),
      .length_i (execLen),
      .hit_o    (execHit)
   );

   pma_range_match #(.AddrW(AddrW)) uCachedMatch (
      .addr_i   (addrQ),
      .base_i   (cachedBase),
      .length_i (cachedLen),
      .hit_o    (cachedHit)
   );

   pma_range_match #(.AddrW(AddrW)) uNonIdMatch (
      .addr_i   (addrQ),
      .base_i   (nonIdBase),
      .length_i (nonIdLen),
      .hit_o    (nonIdHit)
   );

   // Qualify raw comparator hits and detect the final rule index of the walk.
   always_comb begin
      hits.exec    = ruleEn.exec & execHit;
      hits.cached  = ruleEn.cached & cachedHit;
      hits.nonidem = ruleEn.nonidem & nonIdHit;
      lastIdx      = ((32'(idxQ) + 32'd1) >= NMax);
   end

   // Lookup sequencing: accept, walk every rule index, then hold the result
   // until consumed. Flush overrides everything, including handshakes.
   always_comb begin
      stateD = stateQ;
      idxD   = idxQ;
      flagsD = flagsQ;
      addrD  = addrQ;
      unique case (stateQ)
         IDLE: begin
            if (req_valid_i) begin
               addrD  = req_addr_i;
               flagsD = '0;
               idxD   = '0;
               stateD = (NMax == 0) ? RESP : WALK;
            end
         end
         WALK: begin
            flagsD = flagsQ | hits;
            if (lastIdx) begin
               stateD = RESP;
            end else begin
               idxD = idxQ + IdxW'(1);
            end
         end
         RESP: begin
            if (resp_ready_i) begin
               stateD = IDLE;
            end
         end
         default: begin
            stateD = IDLE;
         end
      endcase
      if (flush_i) begin
         stateD = IDLE;
         idxD   = '0;
         flagsD = '0;
      end
   end

   // Walker state registers, cleared asynchronously so a reset abandons any lookup.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stateQ <= IDLE;
         idxQ   <= '0;
         flagsQ <= '0;
         addrQ  <= '0;
      end else begin
         stateQ <= stateD;
         idxQ   <= idxD;
         flagsQ <= flagsD;
         addrQ  <= addrD;
      end
   end

   assign req_ready_o    = (stateQ == IDLE);
   assign resp_valid_o   = (stateQ == RESP);
   assign resp_exec_o    = resp_valid_o & flagsQ.exec;
   assign resp_cached_o  = resp_valid_o & flagsQ.cached;
   assign resp_nonidem_o = resp_valid_o & flagsQ.nonidem;

endmodule

// File: doc/pma_region_walker.md
PMA_REGION_WALKER -- requirements
Module: pma_region_walker

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_t'(0), meaning the core configuration that supplies the rule counts, bases and lengths.
REQ-002 SHALL have parameter AddrW, default 64, meaning the physical address width checked.
REQ-003 SHALL have port clk_i  input  1  core clock; one clock domain only, all state on the rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush_i  input  1  aborts any lookup in progress.
REQ-006 SHALL have port req_valid_i  input  1  lookup request valid.
REQ-007 SHALL have port req_ready_o  output  1  walker can accept a request.
REQ-008 SHALL have port req_addr_i  input  AddrW  physical address to classify.
REQ-009 SHALL have port resp_valid_o  output  1  result valid.
REQ-010 SHALL have port resp_ready_i  input  1  consumer accepts the result.
REQ-011 SHALL have port resp_exec_o  output  1  address is in an execute region.
REQ-012 SHALL have port resp_cached_o  output  1  address is in a cached region.
REQ-013 SHALL have port resp_nonidem_o  output  1  address is in a non-idempotent region.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, WALK, RESP.
REQ-015 SHALL drive req_ready_o=1 only in IDLE; a handshake (req_valid_i & req_ready_o) latches req_addr_i, clears the three sticky hit flags and the index, and moves to WALK.
REQ-016 SHALL define Nmax = max(NrExecuteRegionRules, NrCachedRegionRules, NrNonIdempotentRules).
REQ-017 In WALK, on each cycle SHALL evaluate rule index idx for all three classes in parallel; a class with idx >= its rule count SHALL contribute no hit.
REQ-018 A hit SHALL OR into that class's sticky flag.
REQ-019 After idx = Nmax-1 the FSM SHALL go to RESP; otherwise idx increments by 1.
REQ-020 SHALL define a match as base <= addr < base+length, with the sum computed at AddrW+1 bits so that wrap-around never matches low addresses.
REQ-021 A rule with length 0 SHALL never match.
REQ-022 Latency: for an accept in cycle A, resp_valid_o SHALL be high first in cycle A+Nmax+1.
REQ-023 If Nmax=0, accept SHALL go directly to RESP, and the response SHALL be high in cycle A+1 with all flags 0.
REQ-024 In RESP, resp_valid_o=1 and the flags SHALL be held stable until resp_ready_i=1; the handshake returns the FSM to IDLE.
REQ-025 SHALL not accept a new request in the handshake cycle, so there is one idle cycle between lookups.
REQ-026 resp_*_o flags SHALL be 0 whenever resp_valid_o=0.
REQ-027 flush_i=1 in any state SHALL force IDLE on the next edge and clear idx and the flags.
REQ-028 flush_i SHALL take priority over a same-cycle request or response handshake; a response handshaked in that cycle counts as consumed.
REQ-029 req_addr_i changes after acceptance SHALL not affect the result.

Reset
REQ-030 With rst_ni=0, asynchronously: state=IDLE, idx=0, flags=0, latched address=0.
REQ-031 Reset values of the outputs SHALL be: req_ready_o=1, resp_valid_o=0, resp_exec_o=0, resp_cached_o=0, resp_nonidem_o=0.
REQ-032 Reset asserted mid-WALK or mid-RESP SHALL abandon the lookup, and no response SHALL be emitted after release.

Structure
REQ-033 The FSM state enum and the response struct (exec, cached, nonidem) SHALL live in shared package pma_walker_pkg.
REQ-034 The single combinational comparator SHALL be sub-module pma_range_match (addr, base, length -> hit), instantiated three times.
REQ-035 Rule bases and lengths SHALL be sliced from CVA6Cfg only; there SHALL be no runtime programmability.

Verification
With the cv64a6 config (Nmax=3):
REQ-036 Address 0x8000_1000 -> resp exec=1, cached=1, nonidem=0; resp_valid first high 4 cycles after the accept.
REQ-037 Address 0x500 -> exec=1 (rule 0, base 0x0, length 0x1000), cached=0, nonidem=0; address 0x1000 -> all flags 0 (exclusive upper bound).
REQ-038 Address 0xC000_0000 -> all 0; address 0xBFFF_FFFF -> exec=1, cached=1.
REQ-039 Hold resp_ready_i=0 for 5 cycles -> resp_valid_o and the flags stay stable and req_ready_o=0; the handshake leads to IDLE and req_ready_o=1 on the next cycle.
REQ-040 flush_i pulsed in the second WALK cycle -> no response, IDLE on the next cycle; a following request for 0x8000_0000 -> exec=1, cached=1.
REQ-041 rst_ni pulled low during RESP -> all outputs at reset values immediately; no response after release.
REQ-042 Custom config with base 0xFFFF_FFFF_FFFF_F000 and length 0x2000 -> address 0x10 yields no hit (no wrap-around match).
